// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: one shift cycle and one conditional-subtract cycle per quotient bit.
// Quotient and remainder are held in their working registers and stay valid in DONE and IDLE.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for Run; LoadDivisor captures Din into the divisor
// LOAD  | capture dividend from Din, clear remainder/count, trap D==0
// SHIFT | shift {R,Q} left by one, zero into Q[0]
// SUB   | trial subtract D from R, restore on borrow, set quotient bit
// DONE  | results held; leave on Run low, LoadDivisor honoured
module shift_sub_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             LoadDivisor,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_SUB   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   diff;

    // The extra top bit of diff is the borrow: set means R < D, so restore.
    assign diff = r_q - {1'b0, d_q};

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (LoadDivisor) begin
                    d_d = Din;
                end
                if (Run) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d = '0;
                if (d_q == '0) begin
                    q_d     = '1;
                    r_d     = {1'b0, Din};
                    dbz_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    q_d     = Din;
                    r_d     = '0;
                    dbz_d   = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                r_d     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
                q_d     = q_q << 1;
                state_d = ST_SUB;
            end
            ST_SUB: begin
                if (!diff[WIDTH]) begin
                    r_d    = diff;
                    q_d[0] = 1'b1;
                end else begin
                    q_d[0] = 1'b0;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (LoadDivisor) begin
                    d_d = Din;
                end
                if (!Run) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Quotient  = q_q;
    assign Remainder = r_q[WIDTH-1:0];
    assign Busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_SUB);
    assign Done      = (state_q == ST_DONE);
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and random checks of shift_sub_divider against an arithmetic model of unsigned division.
// Latency is counted in clock edges after the edge that samples Run.
module tb_shift_sub_divider;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Run = 1'b0;
    logic         LoadDivisor = 1'b0;
    logic [W-1:0] Din = '0;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivByZero;

    int vectors = 0;
    int miscompares = 0;
    int d_m = 0;

    shift_sub_divider #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .LoadDivisor(LoadDivisor),
        .Din        (Din),
        .Quotient   (Quotient),
        .Remainder  (Remainder),
        .Busy       (Busy),
        .Done       (Done),
        .DivByZero  (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic load_div(input int v);
        Din = W'(v);
        LoadDivisor = 1'b1;
        step();
        LoadDivisor = 1'b0;
        d_m = v;
    endtask

    // One full operation from IDLE. Expected results come from integer / and %.
    task automatic run_op(input int a, input bit hold_run, input bit poke_ld,
                          input bit ld_with_run, input int new_d);
        int n;
        int exp_q, exp_r, exp_lat, exp_z;
        Din = ld_with_run ? W'(new_d) : W'(a);
        LoadDivisor = ld_with_run;
        Run = 1'b1;
        if (ld_with_run) d_m = new_d;
        if (d_m == 0) begin
            exp_q = (1 << W) - 1; exp_r = a; exp_z = 1; exp_lat = 1;
        end else begin
            exp_q = a / d_m; exp_r = a % d_m; exp_z = 0; exp_lat = 2 * W + 1;
        end
        step();
        Din = W'(a);
        LoadDivisor = 1'b0;
        Run = hold_run;
        chk("busy_after_run", Busy, 1);
        chk("done_after_run", Done, 0);
        n = 0;
        while (Done !== 1'b1 && n < 200) begin
            step();
            n++;
            if (poke_ld && n == 2) begin
                LoadDivisor = 1'b1;
                Din = W'(3);
            end else if (poke_ld && n == 3) begin
                LoadDivisor = 1'b0;
            end
            if (Done !== 1'b1) chk("busy_during_op", Busy, 1);
        end
        LoadDivisor = 1'b0;
        chk("latency", n, exp_lat);
        chk("quotient", Quotient, exp_q);
        chk("remainder", Remainder, exp_r);
        chk("div_by_zero", DivByZero, exp_z);
        chk("busy_in_done", Busy, 0);
        if (hold_run) begin
            repeat (3) step();
            chk("done_held_run", Done, 1);
            chk("quotient_held_run", Quotient, exp_q);
            Run = 1'b0;
        end
        step();
        chk("done_after_idle", Done, 0);
        chk("busy_after_idle", Busy, 0);
        chk("quotient_kept_idle", Quotient, exp_q);
    endtask

    initial begin
        int a, d;
        repeat (2) step();
        chk("rst_quotient", Quotient, 0);
        chk("rst_remainder", Remainder, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_dbz", DivByZero, 0);
        Reset = 1'b0;
        d_m = 0;
        step();

        load_div(7);
        run_op(100, 0, 0, 0, 0);

        load_div(1);
        run_op(255, 0, 0, 0, 0);
        load_div(255);
        run_op(255, 0, 0, 0, 0);
        load_div(9);
        run_op(5, 0, 0, 0, 0);

        load_div(0);
        run_op(200, 0, 0, 0, 0);
        load_div(7);
        run_op(100, 0, 0, 0, 0);

        // Reset landing on the SUB edge of bit 3 (edge 9 after Run is sampled).
        Din = W'(200);
        Run = 1'b1;
        step();
        Run = 1'b0;
        repeat (8) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        d_m = 0;
        chk("midrst_busy", Busy, 0);
        chk("midrst_done", Done, 0);
        chk("midrst_quotient", Quotient, 0);
        chk("midrst_remainder", Remainder, 0);
        chk("midrst_dbz", DivByZero, 0);
        run_op(50, 0, 0, 0, 0);

        load_div(9);
        run_op(200, 1, 1, 0, 0);
        run_op(27, 0, 0, 0, 0);

        run_op(77, 0, 0, 1, 5);
        run_op(77, 0, 0, 1, 0);

        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, (1 << W) - 1));
            d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (1 << W) - 1));
            if ($urandom_range(0, 3) == 0) begin
                run_op(a, 0, 0, 1, d);
            end else begin
                load_div(d);
                run_op(a, $urandom_range(0, 7) == 0, (d != 0) && ($urandom_range(0, 7) == 0), 0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
